// File: rtl/wbs_uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wbs_uart_rx_fifo_pkg
// Purpose : Shared register map and status bit layout for the UART RX FIFO
//           Wishbone slave.
// Contents: UART_REG_* register selects, STAT_* status bit indices,
//           pack_status() helper that builds the STATUS read byte.
// Revision: 1.0 - initial release
// ============================================================================
package wbs_uart_rx_fifo_pkg;

  // Register select on wb_adr_i
  localparam logic UART_REG_DATA   = 1'b0;
  localparam logic UART_REG_STATUS = 1'b1;

  // Bit positions inside the STATUS byte
  localparam int STAT_NONEMPTY = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVERFLOW = 2;

  // Unused bits read as zero.
  function automatic logic [7:0] pack_status(input logic overflow,
                                             input logic full,
                                             input logic nonempty);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_OVERFLOW] = overflow;
    s[STAT_FULL]     = full;
    s[STAT_NONEMPTY] = nonempty;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wbs_uart_rx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wbs_uart_rx_fifo_sync_fifo
// Purpose : Single-clock FIFO of 2**DEPTH_LOG2 entries. A push into a full
//           FIFO is accepted only when a pop happens in the same cycle.
// Ports   : clk, rst_n (async active-low)
//           i_push/i_din   - write request and data
//           i_pop          - read request (ignored when empty)
//           o_head         - oldest entry, valid when !o_empty
//           o_full/o_empty - occupancy flags (registered count)
//           o_nonempty_nxt - occupancy after the current cycle's push/pop
// Revision: 1.0 - initial release
// ============================================================================
module wbs_uart_rx_fifo_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_nonempty_nxt
);

  localparam int                DEPTH        = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_full_count = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  logic                  w_pop_ok;
  logic                  w_push_ok;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == c_full_count);
  assign o_head   = r_mem[r_rd_ptr];

  // When full, the write slot equals the read slot; a same-cycle pop frees it
  // and the head is read before the write lands at the clock edge.
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  assign o_nonempty_nxt = (w_count_nxt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

endmodule
`default_nettype wire

// File: rtl/wbs_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wbs_uart_rx_fifo
// Purpose : Wishbone B4 classic slave buffering bytes from the UART receiver.
//           DATA reads pop the FIFO, STATUS reports {overflow, full,
//           nonempty}, writing STATUS bit 2 clears the sticky overflow flag.
// Ports   : wb_clk_i, wb_rst_ni (async active-low)
//           wb_cyc_i/wb_stb_i/wb_we_i/wb_adr_i/wb_dat_i - bus request
//           wb_dat_o/wb_ack_o - registered response, 1 cycle after request
//           irq_o             - level interrupt, FIFO non-empty
//           rx_dat_i/rx_stb_i - byte from receiver, one-cycle push strobe
// Revision: 1.0 - initial release
// ============================================================================
module wbs_uart_rx_fifo
  import wbs_uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic       wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       irq_o,
  input  logic [7:0] rx_dat_i,
  input  logic       rx_stb_i
);

  logic       r_ack;
  logic [7:0] r_dat;
  logic       r_overflow;
  logic       r_irq;

  logic       w_req;
  logic       w_sel_status;
  logic       w_rd_data;
  logic       w_pop;
  logic       w_ovf_set;
  logic       w_ovf_clr;
  logic [7:0] w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_nonempty_nxt;
  logic       w_unused_dat;

  // Gating with the registered ack makes a held strobe produce an ack every
  // other cycle, never back to back.
  assign w_req        = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_sel_status = (wb_adr_i == UART_REG_STATUS);
  assign w_rd_data    = w_req & ~wb_we_i & (wb_adr_i == UART_REG_DATA);
  assign w_pop        = w_rd_data & ~w_empty;

  // A push into a full FIFO is lost only if no pop frees a slot this cycle.
  assign w_ovf_set    = rx_stb_i & w_full & ~w_pop;
  assign w_ovf_clr    = w_req & wb_we_i & w_sel_status & wb_dat_i[STAT_OVERFLOW];

  // Only the overflow-clear bit of the write data is meaningful.
  assign w_unused_dat = ^wb_dat_i;

  wbs_uart_rx_fifo_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk            (wb_clk_i),
    .rst_n          (wb_rst_ni),
    .i_push         (rx_stb_i),
    .i_din          (rx_dat_i),
    .i_pop          (w_pop),
    .o_head         (w_head),
    .o_full         (w_full),
    .o_empty        (w_empty),
    .o_nonempty_nxt (w_nonempty_nxt)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack      <= 1'b0;
      r_dat      <= 8'h00;
      r_overflow <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_irq <= w_nonempty_nxt;
      // Read data only changes on reads; writes leave the last value held.
      if (w_req && !wb_we_i) begin
        if (w_sel_status)
          r_dat <= pack_status(r_overflow, w_full, ~w_empty);
        else if (w_empty)
          r_dat <= 8'h00;
        else
          r_dat <= w_head;
      end
      // Set has priority over a same-cycle software clear.
      if (w_ovf_set)
        r_overflow <= 1'b1;
      else if (w_ovf_clr)
        r_overflow <= 1'b0;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_wbs_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_wbs_uart_rx_fifo
// Purpose : Directed self-checking bench for wbs_uart_rx_fifo (DEPTH_LOG2=4).
//           Bus reads queue their expected byte; a negedge monitor pops and
//           compares on every ack.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wbs_uart_rx_fifo;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_ni;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic       wb_we_i;
  logic       wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  logic       irq_o;
  logic [7:0] rx_dat_i;
  logic       rx_stb_i;

  always #5 wb_clk_i = ~wb_clk_i;

  wbs_uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .irq_o     (irq_o),
    .rx_dat_i  (rx_dat_i),
    .rx_stb_i  (rx_stb_i)
  );

  typedef struct {
    bit         chk;
    logic [7:0] val;
    int         id;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   ack_total  = 0;
  int   rd_id      = 0;

  // Monitor: every ack consumes one scoreboard entry.
  always @(negedge wb_clk_i) begin
    exp_t e;
    if (wb_ack_o === 1'b1) begin
      ack_total++;
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: ack with empty scoreboard, wb_dat_o=%02h", wb_dat_o);
      end else begin
        e = q.pop_front();
        if (e.chk) begin
          vectors++;
          if (wb_dat_o !== e.val) begin
            miscompares++;
            $display("FAIL read_%0d: wb_dat_o=%02h required %02h", e.id, wb_dat_o, e.val);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h required %02h", name, act, exp);
    end
  endtask

  task automatic sb_push(input bit chk, input logic [7:0] v);
    exp_t e;
    e.chk = chk;
    e.val = v;
    e.id  = rd_id;
    rd_id++;
    q.push_back(e);
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic push_byte(input logic [7:0] d);
    rx_dat_i = d;
    rx_stb_i = 1'b1;
    @(posedge wb_clk_i); #1;
    rx_stb_i = 1'b0;
  endtask

  task automatic bus_read(input logic adr, input logic [7:0] exp);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
    sb_push(1'b1, exp);
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    check("ack_rise", {7'b0, wb_ack_o}, 8'h01);
    @(posedge wb_clk_i); #1;
    check("ack_fall", {7'b0, wb_ack_o}, 8'h00);
  endtask

  task automatic bus_write(input logic adr, input logic [7:0] d);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = adr; wb_dat_i = d;
    sb_push(1'b0, 8'h00);
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    check("wr_ack", {7'b0, wb_ack_o}, 8'h01);
    @(posedge wb_clk_i); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    wb_rst_ni = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 1'b0;
    wb_dat_i = 8'h00; rx_dat_i = 8'h00; rx_stb_i = 1'b0;

    // Reset state
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_ack", {7'b0, wb_ack_o}, 8'h00);
    check("rst_dat", wb_dat_o, 8'h00);
    check("rst_irq", {7'b0, irq_o}, 8'h00);
    wb_rst_ni = 1'b1;
    @(posedge wb_clk_i); #1;

    bus_read(1'b1, 8'h00);
    check("irq_idle", {7'b0, irq_o}, 8'h00);

    // Two bytes in, two out, then empty read
    push_byte(8'hA5);
    check("irq_after_push", {7'b0, irq_o}, 8'h01);
    push_byte(8'h3C);
    bus_read(1'b0, 8'hA5);
    check("irq_one_left", {7'b0, irq_o}, 8'h01);
    bus_read(1'b0, 8'h3C);
    check("irq_drained", {7'b0, irq_o}, 8'h00);
    bus_read(1'b0, 8'h00);

    // Overflow: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    bus_read(1'b1, 8'h07);
    for (int i = 0; i < 16; i++) bus_read(1'b0, 8'(i));
    bus_read(1'b1, 8'h04);
    bus_read(1'b0, 8'h00);
    bus_write(1'b1, 8'h04);
    bus_read(1'b1, 8'h00);

    // Write DATA has no effect
    bus_write(1'b0, 8'hFF);
    bus_read(1'b1, 8'h00);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    bus_read(1'b1, 8'h03);
    rx_dat_i = 8'h99; rx_stb_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 1'b0;
    sb_push(1'b1, 8'h20);
    @(posedge wb_clk_i); #1;
    rx_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    bus_read(1'b1, 8'h03);
    for (int i = 1; i < 16; i++) bus_read(1'b0, 8'h20 + 8'(i));
    bus_read(1'b0, 8'h99);
    bus_read(1'b1, 8'h00);

    // Empty FIFO: push and DATA read in the same cycle, no bypass
    rx_dat_i = 8'h5A; rx_stb_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 1'b0;
    sb_push(1'b1, 8'h00);
    @(posedge wb_clk_i); #1;
    rx_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    bus_read(1'b0, 8'h5A);

    // Reset during an ack
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 1'b0;
    sb_push(1'b1, 8'hC0);
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    check("ack_before_rst", {7'b0, wb_ack_o}, 8'h01);
    wb_rst_ni = 1'b0;
    #1;
    check("ack_async_drop", {7'b0, wb_ack_o}, 8'h00);
    check("irq_async_drop", {7'b0, irq_o}, 8'h00);
    check("dat_async_clr", wb_dat_o, 8'h00);
    q.delete();
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_ni = 1'b1;
    @(posedge wb_clk_i); #1;
    bus_read(1'b1, 8'h00);
    bus_read(1'b0, 8'h00);

    // Pointer wrap: 40 push/pop pairs
    for (int i = 0; i < 40; i++) begin
      push_byte(8'h40 + 8'(i));
      bus_read(1'b0, 8'h40 + 8'(i));
    end
    bus_read(1'b1, 8'h00);

    // Strobe held 4 cycles: acks on alternate cycles, 2 pops
    push_byte(8'hB0);
    push_byte(8'hB1);
    push_byte(8'hB2);
    a0 = ack_total;
    sb_push(1'b1, 8'hB0);
    sb_push(1'b1, 8'hB1);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge wb_clk_i); #1;
      check("ack_hold", {7'b0, wb_ack_o}, (c % 2 == 0) ? 8'h01 : 8'h00);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    check("ack_hold_count", 8'(ack_total - a0), 8'h02);
    bus_read(1'b1, 8'h01);
    bus_read(1'b0, 8'hB2);
    bus_read(1'b1, 8'h00);

    repeat (2) @(posedge wb_clk_i);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d entries left, required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
